debug_arbiter: RTL and testbench

Shares one per-tile debug/log sink among `N_REQ` requesters (core, DMA, NI monitor, …). Each requester has its own small FIFO. A round-robin scheduler drains the FIFOs into the single debug write port. Character writes are line-atomic: once a requester starts a text line, it keeps the sink until it writes a newline, writes a non-character register, or goes idle past a timeout. This keeps log lines from different sources from interleaving.

---
 rtl/debug_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_debug_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_arbiter.sv
// Shares one debug/log sink among N_REQ requesters: per-requester FIFOs drained round-robin,
// with character writes held line-atomic by locking the sink to one source until the line ends.
module debug_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_en_i,
    input  logic [N_REQ*24-1:0]      req_addr_i,
    input  logic [N_REQ*32-1:0]      req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     dbg_en_o,
    output logic                     dbg_we_o,
    output logic [23:0]              dbg_addr_o,
    output logic [31:0]              dbg_data_o,
    output logic [$clog2(N_REQ)-1:0] dbg_src_o,
    input  logic                     dbg_ready_i,
    output logic                     lock_o
);

    localparam int unsigned SRC_W = $clog2(N_REQ);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned ENT_W = 56;

    typedef logic [SRC_W-1:0] idx_t;
    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    localparam idx_t LastIdx = idx_t'(N_REQ - 1);

    function automatic idx_t next_idx(input idx_t i);
        if (i == LastIdx) begin
            return '0;
        end
        return idx_t'(i + idx_t'(1));
    endfunction

    // Per-requester FIFO storage and bookkeeping
    logic [ENT_W-1:0] mem_q  [N_REQ][FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q [N_REQ];
    logic [PTR_W-1:0] rptr_q [N_REQ];
    logic [CNT_W-1:0] cnt_q  [N_REQ];

    logic [N_REQ-1:0] full;
    logic [N_REQ-1:0] empty;
    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;

    // Scheduler state
    state_e           state_q;
    idx_t             rr_q;
    idx_t             owner_q;
    logic [TMR_W-1:0] timer_q;

    logic             win_valid;
    idx_t             win_idx;
    logic [SRC_W:0]   scan;
    logic             out_free;
    logic             load;
    logic [ENT_W-1:0] head;
    logic             head_cont;
    logic             owner_idle;

    always_comb begin
        full        = '0;
        empty       = '0;
        push        = '0;
        pop         = '0;
        req_ready_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            full[i]        = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
            empty[i]       = (cnt_q[i] == '0);
            // No look-ahead on a same-cycle pop: a full FIFO never accepts.
            req_ready_o[i] = !full[i] && !rst_i;
            push[i]        = req_en_i[i] && req_ready_o[i];
            pop[i]         = load && (win_idx == idx_t'(i));
        end
    end

    // Winner: the owner alone while locked, otherwise first non-empty FIFO from rr_q upward.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan      = '0;
        if (state_q == StLocked) begin
            win_idx   = owner_q;
            win_valid = !empty[owner_q];
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                scan = {1'b0, rr_q} + (SRC_W + 1)'(k);
                if (scan >= (SRC_W + 1)'(N_REQ)) begin
                    scan = scan - (SRC_W + 1)'(N_REQ);
                end
                if (!win_valid && !empty[scan[SRC_W-1:0]]) begin
                    win_valid = 1'b1;
                    win_idx   = scan[SRC_W-1:0];
                end
            end
        end
    end

    always_comb begin
        out_free   = !dbg_en_o || dbg_ready_i;
        load       = out_free && win_valid;
        head       = mem_q[win_idx][rptr_q[win_idx]];
        head_cont  = (head[55:32] == 24'h000000) && (head[7:0] != 8'h0A);
        owner_idle = (state_q == StLocked) && empty[owner_q] && out_free;
    end

    assign dbg_we_o = dbg_en_o;

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= {req_addr_i[24*i +: 24], req_data_i[32*i +: 32]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (push[i]) begin
                    wptr_q[i] <= wptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (!push[i] && pop[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            owner_q    <= '0;
            timer_q    <= '0;
            dbg_en_o   <= 1'b0;
            dbg_addr_o <= '0;
            dbg_data_o <= '0;
            dbg_src_o  <= '0;
            lock_o     <= 1'b0;
        end else begin
            // Address/data/source hold their last values when the register drains empty.
            if (out_free) begin
                dbg_en_o <= load;
            end
            if (load) begin
                dbg_addr_o <= head[55:32];
                dbg_data_o <= head[31:0];
                dbg_src_o  <= win_idx;
            end
            case (state_q)
                StIdle: begin
                    if (load) begin
                        rr_q <= next_idx(win_idx);
                        if (head_cont) begin
                            state_q <= StLocked;
                            owner_q <= win_idx;
                            timer_q <= '0;
                            lock_o  <= 1'b1;
                        end
                    end
                end
                StLocked: begin
                    if (load) begin
                        timer_q <= '0;
                        if (!head_cont) begin
                            state_q <= StIdle;
                            rr_q    <= next_idx(owner_q);
                            lock_o  <= 1'b0;
                        end
                    end else if (owner_idle) begin
                        if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                            state_q <= StIdle;
                            rr_q    <= next_idx(owner_q);
                            timer_q <= '0;
                            lock_o  <= 1'b0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    lock_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_arbiter.sv
// Bench for debug_arbiter: directed scenarios plus randomized traffic against a queue-based
// reference model of the arbitration and line-lock rules.
module tb_debug_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int TO    = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_en;
    logic [N*24-1:0] req_addr;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            dbg_en;
    logic            dbg_we;
    logic [23:0]     dbg_addr;
    logic [31:0]     dbg_data;
    logic [1:0]      dbg_src;
    logic            dbg_ready;
    logic            lock;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    debug_arbiter #(
        .N_REQ       (N),
        .FIFO_DEPTH  (DEPTH),
        .LOCK_TIMEOUT(TO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_en_i   (req_en),
        .req_addr_i (req_addr),
        .req_data_i (req_data),
        .req_ready_o(req_ready),
        .dbg_en_o   (dbg_en),
        .dbg_we_o   (dbg_we),
        .dbg_addr_o (dbg_addr),
        .dbg_data_o (dbg_data),
        .dbg_src_o  (dbg_src),
        .dbg_ready_i(dbg_ready),
        .lock_o     (lock)
    );

    // Reference model: one queue per requester plus the sink register and lock bookkeeping.
    logic [55:0] m_q [N][$];
    logic        m_en     = 1'b0;
    logic [23:0] m_addr   = '0;
    logic [31:0] m_data   = '0;
    int          m_src    = 0;
    bit          m_locked = 1'b0;
    int          m_owner  = 0;
    int          m_timer  = 0;
    int          m_rr     = 0;

    task automatic model_step();
        bit [N-1:0]  room;
        bit          free;
        bit          ld;
        bit          cont;
        int          w;
        logic [55:0] e;
        if (rst) begin
            for (int i = 0; i < N; i++) m_q[i].delete();
            m_en = 1'b0; m_addr = '0; m_data = '0; m_src = 0;
            m_locked = 1'b0; m_owner = 0; m_timer = 0; m_rr = 0;
            return;
        end
        for (int i = 0; i < N; i++) room[i] = (m_q[i].size() < DEPTH);
        free = !m_en || dbg_ready;
        ld   = 1'b0;
        w    = 0;
        if (m_locked) begin
            w  = m_owner;
            ld = free && (m_q[w].size() > 0);
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!ld && free && m_q[(m_rr + k) % N].size() > 0) begin
                    ld = 1'b1;
                    w  = (m_rr + k) % N;
                end
            end
        end
        if (free) m_en = ld;
        if (ld) begin
            e      = m_q[w].pop_front();
            m_addr = e[55:32];
            m_data = e[31:0];
            m_src  = w;
            cont   = (e[55:32] == 24'h0) && (e[7:0] != 8'h0A);
            if (m_locked) begin
                m_timer = 0;
                if (!cont) begin
                    m_locked = 1'b0;
                    m_rr     = (m_owner + 1) % N;
                end
            end else begin
                m_rr = (w + 1) % N;
                if (cont) begin
                    m_locked = 1'b1;
                    m_owner  = w;
                    m_timer  = 0;
                end
            end
        end else if (m_locked && free && m_q[m_owner].size() == 0) begin
            if (m_timer == TO - 1) begin
                m_locked = 1'b0;
                m_rr     = (m_owner + 1) % N;
                m_timer  = 0;
            end else begin
                m_timer++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_en[i] && room[i]) m_q[i].push_back({req_addr[24*i +: 24], req_data[32*i +: 32]});
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [23:0] a, input logic [31:0] d);
        req_en[i]          = 1'b1;
        req_addr[24*i +: 24] = a;
        req_data[32*i +: 32] = d;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req_en = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_en    = '0;
        dbg_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (dbg_en !== 1'b0) begin n_errors++; $display("FAIL reset_en got=%0h want=0", dbg_en); end
        n_checks++; if (dbg_we !== 1'b0) begin n_errors++; $display("FAIL reset_we got=%0h want=0", dbg_we); end
        n_checks++; if (dbg_addr !== 24'h0) begin n_errors++; $display("FAIL reset_addr got=%0h want=0", dbg_addr); end
        n_checks++; if (dbg_data !== 32'h0) begin n_errors++; $display("FAIL reset_data got=%0h want=0", dbg_data); end
        n_checks++; if (dbg_src !== 2'd0) begin n_errors++; $display("FAIL reset_src got=%0h want=0", dbg_src); end
        n_checks++; if (lock !== 1'b0) begin n_errors++; $display("FAIL reset_lock got=%0h want=0", lock); end
        n_checks++; if (req_ready !== 4'h0) begin n_errors++; $display("FAIL reset_ready got=%0h want=0", req_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'hF) begin n_errors++; $display("FAIL post_reset_ready got=%0h want=f", req_ready); end
    endtask

    task automatic test_round_robin();
        do_reset();
        dbg_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 24'h0, 32'h0000_000A);
        tick();
        req_en = '0;
        n_checks++; if (dbg_en !== 1'b0) begin n_errors++; $display("FAIL rr_no_bypass got=%0h want=0", dbg_en); end
        for (int k = 0; k < N; k++) begin
            tick();
            n_checks++; if (dbg_en !== 1'b1) begin n_errors++; $display("FAIL rr_en[%0d] got=%0h want=1", k, dbg_en); end
            n_checks++; if (dbg_src !== 2'(k)) begin n_errors++; $display("FAIL rr_src[%0d] got=%0d want=%0d", k, dbg_src, k); end
            n_checks++; if (lock !== 1'b0) begin n_errors++; $display("FAIL rr_lock[%0d] got=%0h want=0", k, lock); end
        end
        tick();
        n_checks++; if (dbg_en !== 1'b0) begin n_errors++; $display("FAIL rr_drained got=%0h want=0", dbg_en); end
    endtask

    task automatic test_line_atomic();
        logic [7:0] s1 [3];
        logic [7:0] s0 [3];
        logic [9:0] exp_l [6];
        logic [9:0] log_q [$];
        int         p;
        s1 = '{8'h41, 8'h42, 8'h0A};
        s0 = '{8'h78, 8'h79, 8'h0A};
        exp_l = '{{2'd1, 8'h41}, {2'd1, 8'h42}, {2'd1, 8'h0A},
                  {2'd0, 8'h78}, {2'd0, 8'h79}, {2'd0, 8'h0A}};
        do_reset();
        dbg_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_en = '0;
            if (c < 3) set_req(1, 24'h0, {24'h0, s1[c]});
            if (c >= 1 && c < 4) set_req(0, 24'h0, {24'h0, s0[c-1]});
            tick();
            if (dbg_en === 1'b1) begin
                p = log_q.size();
                log_q.push_back({dbg_src, dbg_data[7:0]});
                if (p < 6) begin
                    n_checks++;
                    if (lock !== (exp_l[p][7:0] != 8'h0A)) begin
                        n_errors++; $display("FAIL line_lock[%0d] got=%0h want=%0h", p, lock, exp_l[p][7:0] != 8'h0A);
                    end
                end
            end
        end
        req_en = '0;
        n_checks++; if (log_q.size() != 6) begin n_errors++; $display("FAIL line_count got=%0d want=6", log_q.size()); end
        for (int k = 0; k < 6 && k < log_q.size(); k++) begin
            n_checks++;
            if (log_q[k] !== exp_l[k]) begin
                n_errors++; $display("FAIL line_order[%0d] got=%0h want=%0h", k, log_q[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        dbg_ready = 1'b1;
        set_req(2, 24'h0, 32'h0000_0051);
        set_req(3, 24'h0, 32'h0000_000A);
        tick();
        req_en = '0;
        tick();
        n_checks++; if (dbg_en !== 1'b1 || dbg_src !== 2'd2 || dbg_data !== 32'h51) begin
            n_errors++; $display("FAIL to_first got=en%0h/src%0d/%0h want=en1/src2/51", dbg_en, dbg_src, dbg_data);
        end
        n_checks++; if (lock !== 1'b1) begin n_errors++; $display("FAIL to_lock_on got=%0h want=1", lock); end
        for (int t = 0; t < TO - 1; t++) begin
            tick();
            n_checks++; if (lock !== 1'b1 || dbg_en !== 1'b0) begin
                n_errors++; $display("FAIL to_hold[%0d] got=lock%0h/en%0h want=lock1/en0", t, lock, dbg_en);
            end
        end
        tick();
        n_checks++; if (lock !== 1'b0 || dbg_en !== 1'b0) begin
            n_errors++; $display("FAIL to_release got=lock%0h/en%0h want=lock0/en0", lock, dbg_en);
        end
        tick();
        n_checks++; if (dbg_en !== 1'b1 || dbg_src !== 2'd3 || dbg_data !== 32'h0A) begin
            n_errors++; $display("FAIL to_next got=en%0h/src%0d/%0h want=en1/src3/a", dbg_en, dbg_src, dbg_data);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        dbg_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            req_en = '0;
            set_req(0, 24'h000100, 32'h100 + n);
            n_checks++; if (req_ready[0] !== 1'b1) begin n_errors++; $display("FAIL bp_accept[%0d] got=%0h want=1", n, req_ready[0]); end
            tick();
        end
        n_checks++; if (req_ready[0] !== 1'b0) begin n_errors++; $display("FAIL bp_full got=%0h want=0", req_ready[0]); end
        n_checks++; if (dbg_en !== 1'b1 || dbg_addr !== 24'h100 || dbg_data !== 32'h100) begin
            n_errors++; $display("FAIL bp_first got=en%0h/%0h/%0h want=en1/100/100", dbg_en, dbg_addr, dbg_data);
        end
        set_req(0, 24'h000100, 32'h105);
        for (int s = 0; s < 3; s++) begin
            tick();
            n_checks++; if (req_ready[0] !== 1'b0 || dbg_en !== 1'b1 || dbg_data !== 32'h100) begin
                n_errors++; $display("FAIL bp_stall[%0d] got=rdy%0h/en%0h/%0h want=rdy0/en1/100", s, req_ready[0], dbg_en, dbg_data);
            end
        end
        dbg_ready = 1'b1;
        tick();
        n_checks++; if (dbg_data !== 32'h101 || req_ready[0] !== 1'b1) begin
            n_errors++; $display("FAIL bp_first_pop got=%0h/rdy%0h want=101/rdy1", dbg_data, req_ready[0]);
        end
        for (int n = 2; n < 6; n++) begin
            tick();
            req_en = '0;
            n_checks++; if (dbg_en !== 1'b1 || dbg_data !== 32'h100 + n) begin
                n_errors++; $display("FAIL bp_order[%0d] got=en%0h/%0h want=en1/%0h", n, dbg_en, dbg_data, 32'h100 + n);
            end
        end
        tick();
        n_checks++; if (dbg_en !== 1'b0) begin n_errors++; $display("FAIL bp_drained got=%0h want=0", dbg_en); end
    endtask

    task automatic test_halt();
        do_reset();
        dbg_ready = 1'b1;
        set_req(0, 24'h0, 32'h0000_0048);
        tick();
        set_req(0, 24'h000004, 32'h0);
        tick();
        req_en = '0;
        n_checks++; if (dbg_data !== 32'h48 || lock !== 1'b1) begin
            n_errors++; $display("FAIL halt_char got=%0h/lock%0h want=48/lock1", dbg_data, lock);
        end
        tick();
        n_checks++; if (dbg_en !== 1'b1 || dbg_addr !== 24'h4 || dbg_data !== 32'h0 || dbg_src !== 2'd0) begin
            n_errors++; $display("FAIL halt_write got=en%0h/%0h/%0h/src%0d want=en1/4/0/src0", dbg_en, dbg_addr, dbg_data, dbg_src);
        end
        n_checks++; if (lock !== 1'b0) begin n_errors++; $display("FAIL halt_unlock got=%0h want=0", lock); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        dbg_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 24'h8, 32'hDEAD_0000 + i);
        tick();
        tick();
        req_en = '0;
        n_checks++; if (dbg_en !== 1'b1) begin n_errors++; $display("FAIL mid_pre_en got=%0h want=1", dbg_en); end
        rst = 1'b1;
        tick();
        n_checks++; if (dbg_en !== 1'b0 || lock !== 1'b0 || req_ready !== 4'h0) begin
            n_errors++; $display("FAIL mid_rst got=en%0h/lock%0h/rdy%0h want=en0/lock0/rdy0", dbg_en, lock, req_ready);
        end
        rst       = 1'b0;
        dbg_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'hF) begin n_errors++; $display("FAIL mid_ready got=%0h want=f", req_ready); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (dbg_en !== 1'b0) begin n_errors++; $display("FAIL mid_stale[%0d] got=%0h want=0", c, dbg_en); end
        end
        set_req(0, 24'h8, 32'h77);
        set_req(3, 24'h8, 32'h33);
        tick();
        req_en = '0;
        tick();
        n_checks++; if (dbg_en !== 1'b1 || dbg_src !== 2'd0 || dbg_data !== 32'h77) begin
            n_errors++; $display("FAIL mid_rr0 got=en%0h/src%0d/%0h want=en1/src0/77", dbg_en, dbg_src, dbg_data);
        end
        tick();
        n_checks++; if (dbg_en !== 1'b1 || dbg_src !== 2'd3 || dbg_data !== 32'h33) begin
            n_errors++; $display("FAIL mid_rr3 got=en%0h/src%0d/%0h want=en1/src3/33", dbg_en, dbg_src, dbg_data);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_rdy;
        int           ar;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst       = ($urandom_range(0, 999) == 0);
            dbg_ready = ($urandom_range(0, 9) < 7);
            req_en    = '0;
            for (int i = 0; i < N; i++) begin
                // Quiet stretches let lock owners hit the idle timeout.
                if ((cyc % 600) < 450 && $urandom_range(0, 9) < 3) begin
                    ar = $urandom_range(0, 19);
                    set_req(i, (ar < 14) ? 24'h0 : (ar < 17) ? 24'h4 : 24'($urandom),
                            ($urandom_range(0, 3) == 0) ? 32'h0A : $urandom);
                end
            end
            tick();
            for (int i = 0; i < N; i++) exp_rdy[i] = !rst && (m_q[i].size() < DEPTH);
            n_checks++; if (dbg_en !== m_en || dbg_we !== m_en) begin
                n_errors++; $display("FAIL rnd_en[%0d] got=%0h/%0h want=%0h", cyc, dbg_en, dbg_we, m_en);
            end
            n_checks++; if (dbg_addr !== m_addr || dbg_data !== m_data || dbg_src !== 2'(m_src)) begin
                n_errors++; $display("FAIL rnd_out[%0d] got=%0h/%0h/%0d want=%0h/%0h/%0d",
                                     cyc, dbg_addr, dbg_data, dbg_src, m_addr, m_data, m_src);
            end
            n_checks++; if (lock !== m_locked) begin
                n_errors++; $display("FAIL rnd_lock[%0d] got=%0h want=%0h", cyc, lock, m_locked);
            end
            n_checks++; if (req_ready !== exp_rdy) begin
                n_errors++; $display("FAIL rnd_ready[%0d] got=%0h want=%0h", cyc, req_ready, exp_rdy);
            end
        end
        rst    = 1'b0;
        req_en = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_en    = '0;
        req_addr  = '0;
        req_data  = '0;
        dbg_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_line_atomic();
        test_timeout();
        test_backpressure();
        test_halt();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
